// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: icodes, register IDs, data width.
// Imported by the decode/write-back slice.
package y86_pkg;

  localparam int XLEN = 64;

  localparam logic [3:0] IHALT  = 4'h0;
  localparam logic [3:0] INOP   = 4'h1;
  localparam logic [3:0] ICMOV  = 4'h2;
  localparam logic [3:0] IIRMOV = 4'h3;
  localparam logic [3:0] IRMMOV = 4'h4;
  localparam logic [3:0] IMRMOV = 4'h5;
  localparam logic [3:0] IOPQ   = 4'h6;
  localparam logic [3:0] IJXX   = 4'h7;
  localparam logic [3:0] ICALL  = 4'h8;
  localparam logic [3:0] IRET   = 4'h9;
  localparam logic [3:0] IPUSH  = 4'hA;
  localparam logic [3:0] IPOP   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/decode_writeback_if.sv
// Decode/write-back bus: instruction fields and execute/memory results in,
// operands out. master = fetch/execute side, slave = this stage.
interface decode_writeback_if #(
  parameter int XLEN = 64
);
  logic [3:0]      icode;
  logic [3:0]      rA;
  logic [3:0]      rB;
  logic            cnd;
  logic [XLEN-1:0] valE;
  logic [XLEN-1:0] valM;
  logic            wb_en;
  logic [XLEN-1:0] valA;
  logic [XLEN-1:0] valB;

  modport master (
    output icode, rA, rB, cnd, valE, valM, wb_en,
    input  valA, valB
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wb_en,
    output valA, valB
  );
endinterface

// File: rtl/regfile_15x64.sv
// 15-entry register file: 3 async read ports (A, B, debug), 2 sync
// write ports (E, M; M wins on collision), sync active-low clear.
module regfile_15x64 #(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ra_a,
  output logic [XLEN-1:0] rd_a,
  input  logic [3:0]      ra_b,
  output logic [XLEN-1:0] rd_b,
  input  logic [3:0]      ra_d,
  output logic [XLEN-1:0] rd_d,
  input  logic            we_e,
  input  logic [3:0]      wa_e,
  input  logic [XLEN-1:0] wd_e,
  input  logic            we_m,
  input  logic [3:0]      wa_m,
  input  logic [XLEN-1:0] wd_m
);
  import y86_pkg::*;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // RNONE (and anything past the last register) reads as zero
  function automatic logic [XLEN-1:0] rd(input logic [3:0] a,
                                         input logic [XLEN-1:0] r [NREGS]);
    if (int'(a) >= NREGS) return '0;
    return r[a];
  endfunction

  assign rd_a = rd(ra_a, regs_q);
  assign rd_b = rd(ra_b, regs_q);
  assign rd_d = rd(ra_d, regs_q);

  // M applied after E so it wins when both target one register
  always_comb begin
    regs_d = regs_q;
    if (we_e && int'(wa_e) < NREGS) regs_d[wa_e] = wd_e;
    if (we_m && int'(wa_m) < NREGS) regs_d[wa_m] = wd_m;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end
endmodule

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode + write-back: picks srcA/srcB/dstE/dstM from icode,
// reads operands combinationally, commits valE/valM on the clock edge.
module decode_writeback #(
  parameter int XLEN  = 64,
  parameter int NREGS = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_writeback_if.slave   bus,
  input  logic [3:0]          dbg_sel,
  output logic [XLEN-1:0]     dbg_val
);
  import y86_pkg::*;

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (bus.icode)
      ICMOV: begin
        src_a = bus.rA;
        dst_e = bus.cnd ? bus.rB : RNONE;
      end
      IIRMOV: dst_e = bus.rB;
      IRMMOV: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      IMRMOV: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      IOPQ: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      ICALL: begin
        src_b = RRSP;
        dst_e = RRSP;
      end
      IRET: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPUSH: begin
        src_a = bus.rA;
        src_b = RRSP;
        dst_e = RRSP;
      end
      IPOP: begin
        src_a = RRSP;
        src_b = RRSP;
        dst_e = RRSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  regfile_15x64 #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra_a  (src_a),
    .rd_a  (bus.valA),
    .ra_b  (src_b),
    .rd_b  (bus.valB),
    .ra_d  (dbg_sel),
    .rd_d  (dbg_val),
    .we_e  (bus.wb_en),
    .wa_e  (dst_e),
    .wd_e  (bus.valE),
    .we_m  (bus.wb_en),
    .wa_m  (dst_m),
    .wd_m  (bus.valM)
  );
endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed cases plus
// random instructions against a register-array reference model.
module tb_decode_writeback;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  dbg_sel = 4'h0;
  logic [63:0] dbg_val;

  decode_writeback_if #(.XLEN(64)) bus ();

  decode_writeback #(.XLEN(64), .NREGS(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

  always #50 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic [63:0] model [15];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mread(input logic [3:0] id);
    return (id == 4'hF) ? 64'h0 : model[id];
  endfunction

  function automatic logic [3:0] m_src_a(input logic [3:0] ic,
                                         input logic [3:0] ra);
    if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
    if (ic inside {4'h9, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_src_b(input logic [3:0] ic,
                                         input logic [3:0] rb);
    if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_e(input logic [3:0] ic,
                                         input logic [3:0] rb,
                                         input logic c);
    if (ic inside {4'h3, 4'h6}) return rb;
    if (ic == 4'h2) return c ? rb : 4'hF;
    if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dst_m(input logic [3:0] ic,
                                         input logic [3:0] ra);
    if (ic inside {4'h5, 4'hB}) return ra;
    return 4'hF;
  endfunction

  // apply inputs mid-cycle and check the combinational read path
  task automatic drive(input logic [3:0] ic, input logic [3:0] ra,
                       input logic [3:0] rb, input logic c,
                       input logic [63:0] ve, input logic [63:0] vm,
                       input logic wb, input logic rs);
    @(negedge clk);
    bus.icode = ic;
    bus.rA    = ra;
    bus.rB    = rb;
    bus.cnd   = c;
    bus.valE  = ve;
    bus.valM  = vm;
    bus.wb_en = wb;
    rst_n     = rs;
    #1;
    check("valA", bus.valA, mread(m_src_a(ic, ra)));
    check("valB", bus.valB, mread(m_src_b(ic, rb)));
  endtask

  // clock edge, update the model, then sweep the debug port
  task automatic commit();
    logic [3:0] de;
    logic [3:0] dm;
    @(posedge clk);
    de = m_dst_e(bus.icode, bus.rB, bus.cnd);
    dm = m_dst_m(bus.icode, bus.rA);
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) model[i] = 64'h0;
    end else if (bus.wb_en) begin
      if (de != 4'hF) model[de] = bus.valE;
      if (dm != 4'hF) model[dm] = bus.valM;
    end
    #1;
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      check($sformatf("dbg_R%0d", i), dbg_val, mread(4'(i)));
    end
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] r,
                        input logic [63:0] exp);
    drive(4'h6, r, r, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check(tag, bus.valA, exp);
    commit();
  endtask

  initial begin
    for (int i = 0; i < 15; i++) model[i] = 64'h0;

    // 1: reset, then read through an OPq
    drive(4'h1, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    commit();
    drive(4'h6, 4'h0, 4'h3, 1'b0, 64'h0, 64'h0, 1'b0, 1'b1);
    check("t1_valA", bus.valA, 64'h0);
    check("t1_valB", bus.valB, 64'h0);
    commit();

    // 2: irmovq visible next cycle only; wb_en=0 suppresses
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h100, 64'h0, 1'b1, 1'b1);
    commit();
    rd_reg("t2_R2", 4'h2, 64'h100);
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h999, 64'h0, 1'b0, 1'b1);
    commit();
    rd_reg("t2_R2_nowb", 4'h2, 64'h100);

    // 3: cmov gated by cnd
    drive(4'h2, 4'h1, 4'h5, 1'b0, 64'h55, 64'h0, 1'b1, 1'b1);
    commit();
    rd_reg("t3_R5_cnd0", 4'h5, 64'h0);
    drive(4'h2, 4'h1, 4'h5, 1'b1, 64'h55, 64'h0, 1'b1, 1'b1);
    commit();
    rd_reg("t3_R5_cnd1", 4'h5, 64'h55);

    // 4: popq %rsp, valM wins
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'h0, 1'b1, 1'b1);
    commit();
    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h208, 64'hDEAD, 1'b1, 1'b1);
    check("t4_valA", bus.valA, 64'h200);
    check("t4_valB", bus.valB, 64'h200);
    commit();
    rd_reg("t4_R4", 4'h4, 64'hDEAD);

    // 5: call / ret
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h200, 64'h0, 1'b1, 1'b1);
    commit();
    drive(4'h8, 4'hF, 4'hF, 1'b0, 64'h1F8, 64'h0, 1'b1, 1'b1);
    check("t5_call_valB", bus.valB, 64'h200);
    commit();
    rd_reg("t5_R4_call", 4'h4, 64'h1F8);
    drive(4'h9, 4'hF, 4'hF, 1'b0, 64'h200, 64'h0, 1'b1, 1'b1);
    check("t5_ret_valA", bus.valA, 64'h1F8);
    commit();
    rd_reg("t5_R4_ret", 4'h4, 64'h200);

    // 6: reset beats a concurrent write
    drive(4'h3, 4'hF, 4'h7, 1'b0, 64'h77, 64'h0, 1'b1, 1'b0);
    commit();
    rd_reg("t6_R7", 4'h7, 64'h0);
    rd_reg("t6_R4", 4'h4, 64'h0);

    // random instructions
    for (int n = 0; n < 300; n++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 1'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 9) != 0), ($urandom_range(0, 39) != 0));
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
